// File: rtl/piso_serializer_if.sv
// Load-side handshake and serial output bundle for piso_serializer.
interface piso_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] din;
    logic             sout;
    logic             sout_valid;
    logic             done;

    // Word source / serial sink side
    modport master (
        output load_valid,
        output din,
        input  load_ready,
        input  sout,
        input  sout_valid,
        input  done
    );

    // Serializer side
    modport slave (
        input  load_valid,
        input  din,
        output load_ready,
        output sout,
        output sout_valid,
        output done
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: one word per handshake, one bit per clock,
// done pulse in the cycle after the last bit.
module piso_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    piso_serializer_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   shreg;
    logic [CNT_W-1:0]   cnt;
    logic               done_q;
    logic [WIDTH-1:0]   shreg_next_c;
    logic               accept_c;

    // Next shift-register value; the vacated end fills with 0 so an emptied register reads 0
    always_comb begin
        shreg_next_c = shreg;
        if (MSB_FIRST) begin
            shreg_next_c = {shreg[WIDTH-2:0], 1'b0};
        end else begin
            shreg_next_c = {1'b0, shreg[WIDTH-1:1]};
        end
    end

    assign accept_c = bus.load_valid && bus.load_ready;

    // Control FSM, bit counter and shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        shreg <= bus.din;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg <= shreg_next_c;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        cnt    <= '0;
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (accept_c) begin
                        shreg <= bus.din;
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    // Unreachable encoding: recover quietly to IDLE
                    state <= IDLE;
                    shreg <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Outputs decoded straight from flops; sout is a single register bit
    assign bus.load_ready = ((state == IDLE) || (state == DONE)) && !rst;
    assign bus.sout_valid = (state == SHIFT);
    assign bus.sout       = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    assign bus.done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three instances (8/MSB, 8/LSB, 5/MSB) share stimulus,
// each compared every cycle against a remaining-bit-count model.
module tb_piso_serializer;
    logic       clk;
    logic       rst;
    logic       lv;
    logic [7:0] din;

    int checks = 0;
    int errors = 0;

    piso_serializer_if #(.WIDTH(8)) if_m ();
    piso_serializer_if #(.WIDTH(8)) if_l ();
    piso_serializer_if #(.WIDTH(5)) if_5 ();

    assign if_m.load_valid = lv;
    assign if_l.load_valid = lv;
    assign if_5.load_valid = lv;
    assign if_m.din        = din;
    assign if_l.din        = din;
    assign if_5.din        = din[4:0];

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_m (.clk(clk), .rst(rst), .bus(if_m.slave));
    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_l (.clk(clk), .rst(rst), .bus(if_l.slave));
    piso_serializer #(.WIDTH(5), .MSB_FIRST(1'b1)) u_5 (.clk(clk), .rst(rst), .bus(if_5.slave));

    logic [2:0] o_sv, o_so, o_dn, o_rdy;
    assign o_sv  = {if_5.sout_valid, if_l.sout_valid, if_m.sout_valid};
    assign o_so  = {if_5.sout,       if_l.sout,       if_m.sout};
    assign o_dn  = {if_5.done,       if_l.done,       if_m.done};
    assign o_rdy = {if_5.load_ready, if_l.load_ready, if_m.load_ready};

    // Reference model: bits still to emit, the captured word, pending done pulse
    int         rem [3];
    logic [7:0] wrd [3];
    bit         dn  [3];
    logic [7:0] cap [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wid(input int i);
        return (i == 2) ? 5 : 8;
    endfunction

    function automatic bit msb(input int i);
        return (i != 1);
    endfunction

    task automatic chk(input string tag, input int i, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d]: observed %b expected %b", tag, i, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr_cap();
        for (int i = 0; i < 3; i++) cap[i] = 8'h00;
    endtask

    // One clock: drive at negedge, check 1 time unit later, advance model at posedge
    task automatic tick(input bit lv_i, input logic [7:0] d_i, input bit rst_i, input bit do_chk);
        bit   acc [3];
        logic e_sv, e_so, e_rdy;
        int   idx;
        lv  = lv_i;
        din = d_i;
        rst = rst_i;
        #1;
        for (int i = 0; i < 3; i++) begin
            e_sv  = (rem[i] > 0);
            idx   = msb(i) ? (rem[i] - 1) : (wid(i) - rem[i]);
            e_so  = e_sv ? wrd[i][idx] : 1'b0;
            e_rdy = (rem[i] == 0) && !rst_i;
            if (do_chk) begin
                chk("sout_valid", i, o_sv[i],  e_sv);
                chk("sout",       i, o_so[i],  e_so);
                chk("done",       i, o_dn[i],  dn[i]);
                chk("load_ready", i, o_rdy[i], e_rdy);
            end
            if (o_sv[i] === 1'b1) begin
                if (msb(i)) cap[i] = {cap[i][6:0], o_so[i]};
                else        cap[i] = {o_so[i], cap[i][7:1]};
            end
            acc[i] = e_rdy && lv_i;
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (rst_i) begin
                rem[i] = 0;
                dn[i]  = 1'b0;
            end else begin
                dn[i] = (rem[i] == 1);
                if (rem[i] > 0) rem[i] = rem[i] - 1;
                if (acc[i]) begin
                    wrd[i] = (wid(i) == 5) ? (d_i & 8'h1F) : d_i;
                    rem[i] = wid(i);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rem[i] = 0;
            wrd[i] = 8'h00;
            dn[i]  = 1'b0;
        end
        clr_cap();
        lv  = 1'b0;
        rst = 1'b1;
        din = 8'h00;
        @(negedge clk);

        // Reset: first edge unchecked, then reset state with rst still high, then idle
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b1);
        idle(2);

        // Single word 8'hA5
        clr_cap();
        tick(1'b1, 8'hA5, 1'b0, 1'b1);
        idle(10);
        chk8("a5_msb_seq", cap[0], 8'hA5);
        chk8("a5_lsb_seq", cap[1], 8'hA5);
        chk8("a5_w5_seq",  cap[2], 8'h05);

        // Single word 8'h01
        clr_cap();
        tick(1'b1, 8'h01, 1'b0, 1'b1);
        idle(10);
        chk8("01_lsb_seq", cap[1], 8'h01);

        // WIDTH=5 word 5'b10011
        clr_cap();
        tick(1'b1, 8'h13, 1'b0, 1'b1);
        idle(10);
        chk8("w5_10011_seq", cap[2], 8'h13);

        // Back-to-back: F0 held, 0F presented in the 8-bit DONE cycle
        for (int k = 0; k < 9; k++) tick(1'b1, 8'hF0, 1'b0, 1'b1);
        tick(1'b1, 8'h0F, 1'b0, 1'b1);
        idle(12);

        // Busy rejection: C3, then FF offered for 2 cycles mid-word
        tick(1'b1, 8'hC3, 1'b0, 1'b1);
        idle(3);
        tick(1'b1, 8'hFF, 1'b0, 1'b1);
        tick(1'b1, 8'hFF, 1'b0, 1'b1);
        idle(10);

        // Busy then held: FF stays valid until taken in the DONE cycle
        tick(1'b1, 8'hC3, 1'b0, 1'b1);
        idle(3);
        for (int k = 0; k < 7; k++) tick(1'b1, 8'hFF, 1'b0, 1'b1);
        idle(12);

        // Reset mid-word, together with load_valid
        tick(1'b1, 8'h5A, 1'b0, 1'b1);
        idle(4);
        tick(1'b1, 8'h33, 1'b1, 1'b1);
        idle(12);

        // Randomized traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            tick(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 39) == 0), 1'b1);
        end
        idle(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out serializer built around a WIDTH-bit D flip-flop shift register, a bit counter and a 3-state FSM.
- Accepts one parallel word through a valid/ready handshake and emits it one bit per clock on sout, qualified by sout_valid.
- Pulses done after the last bit.
- Sits directly upstream of single-bit flip-flop stages: sout drives a downstream flip-flop's D input, or a JK pair as j=sout, k=~sout.

Parameters:
- WIDTH, 8: word width in bits. Legal range is WIDTH >= 2.
- MSB_FIRST, 1: bit order. 1 = bit WIDTH-1 goes out first; 0 = bit 0 goes out first.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- load_valid  input  1  din holds a word to serialize.
- load_ready  output  1  serializer can accept a word this cycle.
- din  input  WIDTH  parallel word; sampled only on an accepted handshake.
- sout  output  1  serial data bit.
- sout_valid  output  1  sout carries a valid data bit this cycle.
- done  output  1  one-cycle pulse; the last bit of a word was emitted in the previous cycle.

Behaviour:
- State register: {IDLE, SHIFT, DONE}. Counter cnt is $clog2(WIDTH) bits wide.
- Reset (rst=1 at a rising edge):
  - state=IDLE, shift register=0, cnt=0, done=0.
  - rst dominates every other input, including a load_valid in the same cycle.
  - Reset mid-word abandons the word: no done pulse, and sout_valid=0 from the next cycle.
- Combinational outputs:
  - load_ready = (state==IDLE || state==DONE) && !rst.
  - sout_valid = (state==SHIFT).
  - sout = shreg[WIDTH-1] when MSB_FIRST=1, shreg[0] when MSB_FIRST=0.
  - sout is driven directly from a flop bit, so it is glitch-free. It is 0 whenever sout_valid=0.
- Accept: load_valid && load_ready at an edge → shreg<=din, cnt<=0, state<=SHIFT.
  - din is ignored at all other times.
  - load_valid may rise without waiting for load_ready. The source holds din until it is accepted.
- SHIFT, each edge:
  - MSB_FIRST=1: shreg shifts left, filling bit 0 with 0.
  - MSB_FIRST=0: shreg shifts right, filling bit WIDTH-1 with 0.
  - cnt<=cnt+1.
  - When cnt==WIDTH-1 at the edge: state<=DONE, cnt<=0.
- Word timing:
  - Exactly WIDTH consecutive sout_valid cycles per word, with no gaps.
  - The first bit is visible the cycle after acceptance.
- DONE:
  - Lasts one cycle: done=1, sout_valid=0, load_ready=1.
  - If load_valid=1 in this cycle, the new word is accepted and state goes to SHIFT. Otherwise state goes to IDLE.
  - Back-to-back words therefore have a fixed 1-cycle gap: period is WIDTH+1 cycles.
- IDLE: holds, with done=0 and sout_valid=0.
- load_valid during SHIFT is not accepted (load_ready=0) and has no effect on the word in flight.
- cnt never exceeds WIDTH-1, including when WIDTH is not a power of two.
- X-safety: an unreachable state encoding returns to IDLE on the next edge, with done=0.

Test Plan:
- Reset, then WIDTH=8, MSB_FIRST=1, din=8'hA5 with load_valid held for 1 cycle:
  - sout_valid high for 8 cycles starting 1 cycle after acceptance.
  - sout sequence 1,0,1,0,0,1,0,1.
  - done=1 in the following cycle; load_ready=1 throughout IDLE/DONE.
- MSB_FIRST=0, din=8'hA5 → sout sequence 1,0,1,0,0,1,0,1 (LSB first: bits 0..7 of 8'hA5), with done after the 8th bit.
  - Repeat with din=8'h01: 1 then seven 0s.
- Back-to-back: load_valid held high with din=8'hF0, then 8'h0F presented in the DONE cycle:
  - Second word accepted in the DONE cycle.
  - Exactly one non-valid cycle between words.
  - sout = 1111_0000 then 0000_1111.
- Busy rejection: din=8'hC3 accepted; after 3 bits, din=8'hFF with load_valid=1 for 2 cycles:
  - load_ready=0 during SHIFT.
  - The full 1100_0011 is emitted unchanged.
  - 8'hFF is accepted in the DONE cycle because load_valid is still high; otherwise it is not accepted.
- Reset mid-word: assert rst for 1 cycle after the 4th bit of 8'h5A:
  - Next cycle: sout_valid=0, done=0, load_ready=1.
  - No done pulse ever appears for 8'h5A.
  - rst together with load_valid → no acceptance.
- WIDTH=5: din=5'b10011 → 5 valid bits 1,0,0,1,1, then done. cnt wraps correctly at 4 with no extra bit.
